// File: rtl/eth_pktgen.sv
// Ethernet test-frame generator for the 64-bit AXI-Stream TX path.
// Each frame carries a sequence number and a transmit timestamp for latency measurement.
module eth_pktgen #(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0002_0000_0001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          GAP_W     = 16,
    parameter int          CNT_W     = 32
) (
    input  logic             clk156,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [10:0]      cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             s_axis_tx_tvalid,
    input  logic             s_axis_tx_tready,
    output logic [63:0]      s_axis_tx_tdata,
    output logic [7:0]       s_axis_tx_tkeep,
    output logic             s_axis_tx_tlast,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [7:0]         nwords_q, nwords_d;
    logic [7:0]         last_keep_q, last_keep_d;
    logic [7:0]         idx_q, idx_d;
    logic [GAP_W-1:0]   gap_cfg_q, gap_cfg_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   frames_q, frames_d;
    logic               stop_pend_q, stop_pend_d;
    logic [31:0]        seq_q, seq_d;
    logic [63:0]        ts_q, ts_d;
    logic [63:0]        ts_cap_q, ts_cap_d;
    logic               tvalid_q, tvalid_d;
    logic [63:0]        tdata_q, tdata_d;
    logic [7:0]         tkeep_q, tkeep_d;
    logic               tlast_q, tlast_d;

    logic               hs;
    logic               frame_end;
    logic [10:0]        len_clamped;
    logic [CNT_W-1:0]   frames_inc;
    logic               run_done;
    logic [7:0]         idx_next;
    logic               next_is_last;
    logic [63:0]        word0;

    // First byte on the wire sits in tdata[7:0], so multi-byte fields are byte-reversed.
    function automatic logic [63:0] wire_order(input logic [63:0] v);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = v[8*(7-b) +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] frame_word(input logic [7:0] idx,
                                               input logic [31:0] seq,
                                               input logic [63:0] ts);
        case (idx)
            8'd0:    frame_word = wire_order({DST_MAC, SRC_MAC[47:32]});
            8'd1:    frame_word = wire_order({SRC_MAC[31:0], ETHERTYPE, 16'h0000});
            8'd2:    frame_word = wire_order({32'h0000_0000, seq});
            8'd3:    frame_word = wire_order(ts);
            default: frame_word = {8{idx}};
        endcase
    endfunction

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len < 11'd60) begin
            len_clamped = 11'd60;
        end else if (cfg_len > 11'd1514) begin
            len_clamped = 11'd1514;
        end
    end

    assign hs           = tvalid_q & s_axis_tx_tready;
    assign frame_end    = hs & tlast_q;
    assign frames_inc   = frames_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign run_done     = stop_pend_q | stop | ((count_q != '0) && (frames_inc == count_q));
    assign idx_next     = idx_q + 8'd1;
    assign next_is_last = (idx_next == (nwords_q - 8'd1));
    assign word0        = frame_word(8'd0, 32'h0, 64'h0);

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_q     <= IDLE;
            nwords_q    <= '0;
            last_keep_q <= '0;
            idx_q       <= '0;
            gap_cfg_q   <= '0;
            gap_cnt_q   <= '0;
            count_q     <= '0;
            frames_q    <= '0;
            stop_pend_q <= 1'b0;
            seq_q       <= '0;
            ts_q        <= '0;
            ts_cap_q    <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nwords_q    <= nwords_d;
            last_keep_q <= last_keep_d;
            idx_q       <= idx_d;
            gap_cfg_q   <= gap_cfg_d;
            gap_cnt_q   <= gap_cnt_d;
            count_q     <= count_d;
            frames_q    <= frames_d;
            stop_pend_q <= stop_pend_d;
            seq_q       <= seq_d;
            ts_q        <= ts_d;
            ts_cap_q    <= ts_cap_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) state_d = SEND;
            end
            SEND: begin
                if (frame_end) begin
                    if (run_done)               state_d = IDLE;
                    else if (gap_cfg_q == '0)   state_d = SEND;
                    else                        state_d = GAP;
                end
            end
            GAP: begin
                if (stop)                       state_d = IDLE;
                else if (gap_cnt_q <= 1)        state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so the next word is prepared on the handshake that retires the current one.
    always_comb begin
        nwords_d    = nwords_q;
        last_keep_d = last_keep_q;
        idx_d       = idx_q;
        gap_cfg_d   = gap_cfg_q;
        gap_cnt_d   = gap_cnt_q;
        count_d     = count_q;
        frames_d    = frames_q;
        stop_pend_d = stop_pend_q;
        seq_d       = seq_q;
        ts_d        = ts_q + 64'd1;
        ts_cap_d    = ts_cap_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    nwords_d    = len_clamped[10:3] + {7'd0, (len_clamped[2:0] != 3'd0)};
                    last_keep_d = (len_clamped[2:0] == 3'd0) ? 8'hFF
                                : (8'h01 << len_clamped[2:0]) - 8'h01;
                    gap_cfg_d   = cfg_gap;
                    count_d     = cfg_count;
                    frames_d    = '0;
                    seq_d       = '0;
                    stop_pend_d = 1'b0;
                    idx_d       = '0;
                    tvalid_d    = 1'b1;
                    tdata_d     = word0;
                    tkeep_d     = 8'hFF;
                    tlast_d     = 1'b0;
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (hs && (idx_q == 8'd0)) ts_cap_d = ts_q;
                if (frame_end) begin
                    frames_d = frames_inc;
                    seq_d    = seq_q + 32'd1;
                    idx_d    = '0;
                    if (state_d == SEND) begin
                        tdata_d = word0;
                        tkeep_d = 8'hFF;
                        tlast_d = 1'b0;
                    end else begin
                        tvalid_d  = 1'b0;
                        tdata_d   = '0;
                        tkeep_d   = '0;
                        tlast_d   = 1'b0;
                        gap_cnt_d = gap_cfg_q;
                        if (state_d == IDLE) stop_pend_d = 1'b0;
                    end
                end else if (hs) begin
                    idx_d   = idx_next;
                    tdata_d = frame_word(idx_next, seq_q, ts_cap_q);
                    tkeep_d = next_is_last ? last_keep_q : 8'hFF;
                    tlast_d = next_is_last;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q <= 1) begin
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = word0;
                    tkeep_d  = 8'hFF;
                    tlast_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s_axis_tx_tvalid = tvalid_q;
        s_axis_tx_tdata  = tdata_q;
        s_axis_tx_tkeep  = tkeep_q;
        s_axis_tx_tlast  = tlast_q;
        busy             = (state_q != IDLE);
        frames_sent      = frames_q;
    end

endmodule

// File: tb/tb_eth_pktgen.sv
// Self-checking bench for eth_pktgen: per-scenario tasks feed an expected-word
// scoreboard that a negedge monitor drains on every AXIS handshake.
module tb_eth_pktgen;

    localparam logic [47:0] DST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC   = 48'h0002_0000_0001;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [10:0] cfg_len;
    logic [15:0] cfg_gap;
    logic [31:0] cfg_count;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        busy;
    logic [31:0] frames_sent;

    eth_pktgen dut (
        .clk156           (clk),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .cfg_len          (cfg_len),
        .cfg_gap          (cfg_gap),
        .cfg_count        (cfg_count),
        .s_axis_tx_tvalid (tvalid),
        .s_axis_tx_tready (tready),
        .s_axis_tx_tdata  (tdata),
        .s_axis_tx_tkeep  (tkeep),
        .s_axis_tx_tlast  (tlast),
        .busy             (busy),
        .frames_sent      (frames_sent)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          kind;   // 1 = word 0, 2 = timestamp word, 0 = other
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ts_log[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          tlast_cnt = 0;
    int          exp_gap = 0;
    bit          bp_en = 0;
    logic [63:0] tb_ts;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) tb_ts <= reset ? 64'd0 : tb_ts + 64'd1;

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [63:0] pack_bytes(input logic [7:0] b [8]);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = b[k];
        return r;
    endfunction

    function automatic logic [63:0] ts_word(input logic [63:0] v);
        logic [7:0] b [8];
        for (int k = 0; k < 8; k++) b[k] = v[63-8*k -: 8];
        return pack_bytes(b);
    endfunction

    function automatic logic [63:0] exp_word(input int i, input logic [31:0] seq);
        logic [7:0]  b [8];
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] e;
        d = DST;
        s = SRC;
        e = ETYPE;
        case (i)
            0: b = '{d[47:40], d[39:32], d[31:24], d[23:16], d[15:8], d[7:0], s[47:40], s[39:32]};
            1: b = '{s[31:24], s[23:16], s[15:8], s[7:0], e[15:8], e[7:0], 8'h00, 8'h00};
            2: b = '{8'h00, 8'h00, 8'h00, 8'h00, seq[31:24], seq[23:16], seq[15:8], seq[7:0]};
            default: for (int k = 0; k < 8; k++) b[k] = 8'(i);
        endcase
        return pack_bytes(b);
    endfunction

    task automatic push_frame(input int len_raw, input logic [31:0] seq);
        int   l;
        int   n;
        int   r;
        exp_t e;
        l = (len_raw < 60) ? 60 : (len_raw > 1514) ? 1514 : len_raw;
        n = (l + 7) / 8;
        r = l % 8;
        for (int i = 0; i < n; i++) begin
            e.data = exp_word(i, seq);
            e.kind = (i == 0) ? 1 : (i == 3) ? 2 : 0;
            e.last = (i == n - 1);
            e.keep = (i != n - 1) ? 8'hFF : (r == 0) ? 8'hFF : (8'hFF >> (8 - r));
            sb.push_back(e);
        end
    endtask

    // Monitor: compares handshaked words, AXIS hold rules and inter-frame idle cycles.
    initial begin
        exp_t        e;
        logic [63:0] expd;
        logic [63:0] cur_ts;
        logic        prev_stall;
        logic [63:0] prev_data;
        logic [7:0]  prev_keep;
        logic        prev_last;
        bit          in_frame;
        bit          gap_on;
        int          idle_run;
        prev_stall = 0; in_frame = 0; gap_on = 0; idle_run = 0; cur_ts = '0;
        prev_data = '0; prev_keep = '0; prev_last = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0; in_frame = 0; gap_on = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (tvalid !== 1'b1 || tdata !== prev_data || tkeep !== prev_keep || tlast !== prev_last) begin
                        errors++;
                        $display("FAIL hold_stable: got v=%b d=%h k=%h l=%b required v=1 d=%h k=%h l=%b",
                                 tvalid, tdata, tkeep, tlast, prev_data, prev_keep, prev_last);
                    end
                end
                if (in_frame) begin
                    checks++;
                    if (tvalid !== 1'b1) begin
                        errors++;
                        $display("FAIL valid_mid_frame: got %b required 1", tvalid);
                    end
                end
                if (gap_on) begin
                    if (!busy) gap_on = 0;
                    else if (tvalid) begin
                        checks++;
                        if (idle_run != exp_gap) begin
                            errors++;
                            $display("FAIL gap_cycles: got %0d required %0d", idle_run, exp_gap);
                        end
                        gap_on = 0;
                    end else idle_run++;
                end
                if (tvalid && tready) begin
                    hs_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got d=%h required none", tdata);
                    end else begin
                        e = sb.pop_front();
                        expd = e.data;
                        if (e.kind == 1) begin
                            cur_ts = tb_ts;
                            ts_log.push_back(tb_ts);
                        end
                        if (e.kind == 2) expd = ts_word(cur_ts);
                        if (tdata !== expd) begin
                            errors++;
                            $display("FAIL word_data: got %h required %h", tdata, expd);
                        end
                        checks++;
                        if (tkeep !== e.keep || tlast !== e.last) begin
                            errors++;
                            $display("FAIL word_keep_last: got k=%h l=%b required k=%h l=%b",
                                     tkeep, tlast, e.keep, e.last);
                        end
                    end
                    in_frame = !tlast;
                    if (tlast) begin
                        tlast_cnt++;
                        gap_on = 1;
                        idle_run = 0;
                    end
                end
                prev_stall = tvalid && !tready;
                prev_data = tdata; prev_keep = tkeep; prev_last = tlast;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input int gap, input int cnt);
        cfg_len = 11'(len);
        cfg_gap = 16'(gap);
        cfg_count = 32'(cnt);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        cfg_len = 11'd0; cfg_gap = 16'd0; cfg_count = 32'd0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && busy; i++) tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: got busy=%b required 0", name, busy);
        end
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        for (int i = 0; i < budget && hs_cnt < target; i++) tick(1);
        checks++;
        if (hs_cnt != target) begin
            errors++;
            $display("FAIL %s_hs_timeout: got %0d required %0d", name, hs_cnt, target);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        check_int("reset_outputs_zero", {tvalid, tkeep, tlast, busy} == 0 && tdata == 0 ? 1 : 0, 1);
        check_int("reset_frames_sent", frames_sent, 0);
        reset = 1'b0;
        tick(2);
        $display("test_reset: tvalid=%b busy=%b frames_sent=%0d", tvalid, busy, frames_sent);
    endtask

    task automatic test_start_with_stop();
        start = 1'b1; stop = 1'b1; cfg_len = 11'd64; cfg_count = 32'd1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        tick(1);
        check_int("start_and_stop_stays_idle", busy, 0);
        check_int("start_and_stop_no_valid", tvalid, 0);
        $display("test_start_with_stop: busy=%b", busy);
    endtask

    task automatic test_back_to_back();
        int h0 = hs_cnt;
        int t0 = tlast_cnt;
        exp_gap = 0;
        for (int f = 0; f < 3; f++) push_frame(64, 32'(f));
        do_start(64, 0, 3);
        check_int("b2b_busy_after_start", busy, 1);
        for (int i = 0; i < 100 && tlast_cnt < t0 + 3; i++) tick(1);
        check_int("b2b_busy_falls", busy, 0);
        check_int("b2b_valid_falls", tvalid, 0);
        check_int("b2b_word_count", hs_cnt - h0, 24);
        check_int("b2b_frames_sent", frames_sent, 3);
        check_int("b2b_drained", sb.size(), 0);
        $display("test_back_to_back: words=%0d frames_sent=%0d", hs_cnt - h0, frames_sent);
    endtask

    task automatic test_gap();
        int h0 = hs_cnt;
        exp_gap = 5;
        ts_log.delete();
        push_frame(61, 0);
        push_frame(61, 1);
        do_start(61, 5, 2);
        wait_idle(200, "gap");
        check_int("gap_word_count", hs_cnt - h0, 16);
        check_int("gap_ts_frames", ts_log.size(), 2);
        if (ts_log.size() == 2) check_int("gap_ts_delta", longint'(ts_log[1] - ts_log[0]), 13);
        check_int("gap_frames_sent", frames_sent, 2);
        check_int("gap_drained", sb.size(), 0);
        $display("test_gap: words=%0d frames_sent=%0d", hs_cnt - h0, frames_sent);
    endtask

    task automatic test_clamp();
        int h0;
        exp_gap = 0;
        h0 = hs_cnt;
        push_frame(40, 0);
        do_start(40, 0, 1);
        wait_idle(100, "clamp_min");
        check_int("clamp_min_words", hs_cnt - h0, 8);
        h0 = hs_cnt;
        push_frame(2000, 0);
        do_start(2000, 0, 1);
        wait_idle(400, "clamp_max");
        check_int("clamp_max_words", hs_cnt - h0, 190);
        check_int("clamp_drained", sb.size(), 0);
        $display("test_clamp: last run words=%0d", hs_cnt - h0);
    endtask

    task automatic test_backpressure();
        int t0 = tlast_cnt;
        exp_gap = 0;
        for (int f = 0; f < 10; f++) push_frame(128, 32'(f));
        bp_en = 1;
        do_start(128, 0, 10);
        wait_idle(3000, "bp");
        bp_en = 0;
        check_int("bp_tlast_count", tlast_cnt - t0, 10);
        check_int("bp_frames_sent", frames_sent, 10);
        check_int("bp_drained", sb.size(), 0);
        $display("test_backpressure: tlasts=%0d frames_sent=%0d", tlast_cnt - t0, frames_sent);
    endtask

    task automatic test_stop_send();
        int h0 = hs_cnt;
        int t0 = tlast_cnt;
        exp_gap = 0;
        for (int f = 0; f < 5; f++) push_frame(64, 32'(f));
        do_start(64, 0, 0);
        wait_hs(h0 + 35, 200, "stop_send");
        pulse_stop();
        wait_idle(100, "stop_send");
        tick(10);
        check_int("stop_send_frames_sent", frames_sent, 5);
        check_int("stop_send_tlasts", tlast_cnt - t0, 5);
        check_int("stop_send_no_valid", tvalid, 0);
        check_int("stop_send_drained", sb.size(), 0);
        $display("test_stop_send: frames_sent=%0d", frames_sent);
    endtask

    task automatic test_stop_gap();
        int t0 = tlast_cnt;
        exp_gap = 20;
        push_frame(60, 0);
        do_start(60, 20, 0);
        for (int i = 0; i < 100 && tlast_cnt < t0 + 1; i++) tick(1);
        tick(3);
        check_int("stop_gap_in_gap", busy, 1);
        pulse_stop();
        check_int("stop_gap_idle_next", busy, 0);
        tick(30);
        check_int("stop_gap_no_valid", tvalid, 0);
        check_int("stop_gap_frames_sent", frames_sent, 1);
        check_int("stop_gap_drained", sb.size(), 0);
        $display("test_stop_gap: busy=%b frames_sent=%0d", busy, frames_sent);
    endtask

    task automatic test_reset_midframe();
        int h0 = hs_cnt;
        exp_gap = 0;
        push_frame(64, 0);
        push_frame(64, 1);
        do_start(64, 0, 0);
        wait_hs(h0 + 14, 200, "reset_mid");
        check_int("reset_mid_pre_frames", frames_sent, 1);
        reset = 1'b1;
        tick(1);
        check_int("reset_mid_valid", tvalid, 0);
        check_int("reset_mid_tlast", tlast, 0);
        check_int("reset_mid_frames_sent", frames_sent, 0);
        reset = 1'b0;
        sb.delete();
        tick(2);
        push_frame(64, 0);
        do_start(64, 0, 1);
        wait_idle(100, "reset_restart");
        check_int("reset_restart_frames", frames_sent, 1);
        check_int("reset_restart_drained", sb.size(), 0);
        $display("test_reset_midframe: frames_sent=%0d", frames_sent);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_len = 11'd0; cfg_gap = 16'd0; cfg_count = 32'd0;
        test_reset();
        test_start_with_stop();
        test_back_to_back();
        test_gap();
        test_clamp();
        test_backpressure();
        test_stop_send();
        test_stop_gap();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_pktgen.md
Name: eth_pktgen

Overview:
- Parametrised successor to the fixed-pattern eth_send generator.
- Produces back-to-back or gap-spaced Ethernet frames on the 64-bit AXI-Stream TX path, upstream of the pcie2eth_fifo and the 10G MAC.
- Frame length, inter-frame gap and frame count are run-time configurable.
- Every frame carries a sequence number and a 64-bit transmit timestamp taken from a free-running cycle counter, for latency measurement.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC inserted in every frame
SRC_MAC, 48'h0002_0000_0001, source MAC
ETHERTYPE, 16'h88B5, EtherType field
GAP_W, 16, width of cfg_gap
CNT_W, 32, width of cfg_count and frames_sent

Ports:
clk156  in  1  TX clock; all logic in this domain
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a run
stop  in  1  single-cycle pulse; ends a run gracefully
cfg_len  in  11  frame length in bytes, excluding FCS
cfg_gap  in  GAP_W  idle cycles between frames
cfg_count  in  CNT_W  frames per run; 0 = unlimited
s_axis_tx_tvalid  out  1  AXIS valid
s_axis_tx_tready  in  1  AXIS ready
s_axis_tx_tdata  out  64  AXIS data; byte 0 on wire = tdata[7:0]
s_axis_tx_tkeep  out  8  AXIS byte enables
s_axis_tx_tlast  out  1  last word of frame
busy  out  1  high whenever state is not IDLE
frames_sent  out  CNT_W  frames completed in current or last run

Behaviour:
- Reset values: tvalid=0, tdata=0, tkeep=0, tlast=0, busy=0, frames_sent=0, state=IDLE, seq=0, ts_counter=0.
- Reset asserted mid-frame: tvalid drops on the next edge; no tlast is emitted.
- ts_counter: 64-bit, increments every cycle after reset, wraps at 2^64.
- FSM states: IDLE, SEND, GAP.
- IDLE -> SEND on start=1 and stop=0:
  - latch cfg_len, cfg_gap and cfg_count;
  - clear frames_sent and seq;
  - tvalid=1 on the next cycle.
- start=1 with stop=1 in IDLE: stay in IDLE. start outside IDLE is ignored. Config changes during a run are ignored.
- Length clamp: latched len <60 becomes 60; >1514 becomes 1514.
- Word count: nwords = ceil(len/8), giving 8..190 words.
- Frame words (index i, 0-based):
  - i=0: {SRC_MAC[47:32], DST_MAC}, wire order DST byte 5 first.
  - i=1: {16'h0, ETHERTYPE, SRC_MAC[31:0]}, same big-endian-on-wire byte ordering.
  - i=2: {32'h0, seq}, big-endian on wire.
  - i=3: 64-bit timestamp, big-endian on wire. Value is ts_counter captured on the cycle word 0 handshakes (tvalid&tready).
  - i>=4: every byte equals i[7:0].
- tkeep: 8'hFF on all words except the last. On the last word, r = len mod 8; tkeep = 8'hFF if r=0, else (1<<r)-1. tlast=1 only on word nwords-1.
- AXIS rules:
  - Once tvalid=1, tdata, tkeep and tlast hold stable until tready=1.
  - tvalid never drops mid-frame, except on reset.
  - Advance one word per handshake.
- On the tlast handshake: frames_sent++ and seq++ (32-bit wrap). Next state is chosen in this priority:
  1. stop pending, or (cfg_count!=0 and new frames_sent==cfg_count): go to IDLE; tvalid=0 the next cycle.
  2. gap=0: stay in SEND; word 0 of the next frame is valid the next cycle.
  3. Otherwise: go to GAP, tvalid=0, load the gap counter with gap.
- GAP: decrement the counter each cycle; on reaching 0 go to SEND. Exactly gap cycles with tvalid=0 between tlast handshake and next tvalid.
- stop:
  - in SEND: set a pending flag; the current frame completes, never truncated.
  - in GAP: go to IDLE on the next edge.
  - in IDLE: no effect.
  - The pending flag clears on entry to IDLE.
- frames_sent holds its value in IDLE until the next start.
- No combinational path from s_axis_tx_tready to any output.

Test Plan:
- cfg_len=64, cfg_gap=0, cfg_count=3, tready=1 -> exactly 24 words; tlast on words 7, 15, 23; tkeep=8'hFF throughout; seq fields 0, 1, 2; frames_sent=3; busy falls after the last handshake.
- cfg_len=61, cfg_gap=5, cfg_count=2 -> each frame 8 words; last tkeep=8'h1F; exactly 5 tvalid=0 cycles between frames; timestamp difference between frames = 8+5=13.
- cfg_len=40 and cfg_len=2000 -> frames of 60 bytes (8 words, last tkeep=8'h0F) and 1514 bytes (190 words, last tkeep=8'h03).
- Random tready backpressure (~50%), cfg_len=128, cfg_count=10 -> data stable while tvalid&!tready; words 4..15 bytes equal index; 10 tlasts.
- cfg_count=0, then stop at word 3 of frame 5 -> frame 5 completes with tlast; FSM returns to IDLE; frames_sent=5. Also: stop during GAP -> IDLE next cycle with no further tvalid.
- Assert reset at word 6 of a frame -> tvalid=0 next cycle, frames_sent=0; a new start then begins with seq=0.
